// File: rtl/spi_xfer_arb.sv
// Round-robin arbiter/sequencer sharing one 16-bit SPI master between NREQ requesters.
// Launches one wrt/done transaction per grant, enforces an idle gap, flags a hung master.
module spi_xfer_arb #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned TMO_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst_cnt,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_cmd,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      gnt,
    output logic [15:0]          rsp_data,
    output logic                 busy,
    output logic                 err_tmo,
    output logic                 wrt,
    output logic [15:0]          cmd,
    input  logic                 done,
    input  logic [15:0]          rd_data
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned GW = $clog2(GAP_CYC + 1);
    localparam int unsigned TW = $clog2(TMO_CYC);

    typedef enum logic [2:0] {IDLE, LAUNCH, ARM, XFER, GAP} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     last_gnt;
    logic [IW-1:0]     win;
    logic [NREQ-1:0]   win_oh;
    logic [15:0]       cmd_sel;
    logic              any_req;
    logic [GW-1:0]     gap_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic              done_hit;
    logic              tmo_hit;

    // Search starts one past the previous owner so every requester is reached within NREQ grants.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        win     = last_gnt;
        any_req = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_gnt) + k) % NREQ;
            if (!any_req && req[IW'(idx)]) begin
                any_req = 1'b1;
                win     = IW'(idx);
            end
        end
    end

    always_comb begin
        cmd_sel = '0;
        win_oh  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                cmd_sel   = req_cmd[16*i +: 16];
                win_oh[i] = 1'b1;
            end
        end
    end

    // A completion seen in the same cycle as the timeout threshold is treated as a normal finish.
    assign done_hit = (state == XFER) && done;
    assign tmo_hit  = ((state == ARM) || (state == XFER)) && !done_hit
                      && (tmo_cnt == TW'(TMO_CYC - 1));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = LAUNCH;
            LAUNCH:  state_nx = ARM;
            ARM:     if (tmo_hit) state_nx = GAP;
                     else if (!done) state_nx = XFER;
            XFER:    if (done_hit || tmo_hit) state_nx = GAP;
            GAP:     if (gap_cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_cnt) begin
        if (rst_cnt) begin
            state    <= IDLE;
            last_gnt <= IW'(NREQ - 1);
            gnt      <= '0;
            ack      <= '0;
            cmd      <= '0;
            rsp_data <= '0;
            err_tmo  <= 1'b0;
            gap_cnt  <= '0;
            tmo_cnt  <= '0;
        end else begin
            state <= state_nx;
            ack   <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt      <= win_oh;
                        cmd      <= cmd_sel;
                        last_gnt <= win;
                        tmo_cnt  <= '0;
                    end
                end
                LAUNCH, ARM, XFER: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (done_hit || tmo_hit) begin
                        ack     <= gnt;
                        gap_cnt <= GW'(GAP_CYC);
                    end
                    if (done_hit) rsp_data <= rd_data;
                    if (tmo_hit)  err_tmo  <= 1'b1;
                end
                GAP: begin
                    if (gap_cnt == '0) gnt <= '0;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wrt  = (state == LAUNCH);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_xfer_arb.sv
// Directed bench for spi_xfer_arb: instance a uses the default timeout, instance b a 16-cycle
// timeout; each has its own behavioural SPI master model.
module tb_spi_xfer_arb;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_cnt;
    logic [2:0]  req = '0;
    logic [47:0] req_cmd = '0;
    logic [2:0]  ack_a, gnt_a, ack_b, gnt_b;
    logic [15:0] rsp_a, rsp_b, cmd_a, cmd_b;
    logic [15:0] rd_a = '0, rd_b = '0;
    logic        busy_a, busy_b, err_a, err_b, wrt_a, wrt_b;
    logic        done_a, done_b;
    logic        hang_b = 1'b0;
    int          len_a = 40, len_b = 14, cnt_a = 0, cnt_b = 0;
    int          cyc = 0;
    int          n_run = 0, n_fail = 0;

    int          t0, w, w2, a, e, nw, ngr, last_ack, k, found, n_ack;
    int          rr [3];
    logic [2:0]  exp_g;

    spi_xfer_arb #(.NREQ(3), .GAP_CYC(GAP)) dut_a (
        .clk(clk), .rst_cnt(rst_cnt), .req(req), .req_cmd(req_cmd),
        .ack(ack_a), .gnt(gnt_a), .rsp_data(rsp_a), .busy(busy_a), .err_tmo(err_a),
        .wrt(wrt_a), .cmd(cmd_a), .done(done_a), .rd_data(rd_a)
    );

    spi_xfer_arb #(.NREQ(3), .GAP_CYC(GAP), .TMO_CYC(16)) dut_b (
        .clk(clk), .rst_cnt(rst_cnt), .req(req), .req_cmd(req_cmd),
        .ack(ack_b), .gnt(gnt_b), .rsp_data(rsp_b), .busy(busy_b), .err_tmo(err_b),
        .wrt(wrt_b), .cmd(cmd_b), .done(done_b), .rd_data(rd_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Master: done drops the cycle after wrt and stays low for len cycles.
    always @(posedge clk or posedge rst_cnt) begin
        if (rst_cnt) begin
            done_a <= 1'b1; cnt_a <= 0;
        end else if (wrt_a) begin
            done_a <= 1'b0; cnt_a <= len_a;
        end else if (!done_a) begin
            if (cnt_a <= 1) done_a <= 1'b1;
            else            cnt_a  <= cnt_a - 1;
        end
    end

    always @(posedge clk or posedge rst_cnt) begin
        if (rst_cnt) begin
            done_b <= 1'b1; cnt_b <= 0;
        end else if (wrt_b && !hang_b) begin
            done_b <= 1'b0; cnt_b <= len_b;
        end else if (!done_b) begin
            if (cnt_b <= 1) done_b <= 1'b1;
            else            cnt_b  <= cnt_b - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_rst_a(input string tag);
        chk({tag, "_wrt"},  wrt_a,  0);
        chk({tag, "_cmd"},  cmd_a,  0);
        chk({tag, "_ack"},  ack_a,  0);
        chk({tag, "_gnt"},  gnt_a,  0);
        chk({tag, "_rsp"},  rsp_a,  0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_err"},  err_a,  0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst_cnt = 1'b1;
        @(negedge clk); rst_cnt = 1'b0;
    endtask

    task automatic wait_wrt(input bit use_b, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (use_b ? wrt_b : wrt_a) begin at = cyc; break; end
        end
    endtask

    task automatic wait_ack(input bit use_b, input int budget, output int at, output int nwrt);
        at = -1; nwrt = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (use_b ? wrt_b : wrt_a) nwrt++;
            if ((use_b ? ack_b : ack_a) != 3'b000) begin at = cyc; break; end
        end
    endtask

    task automatic wait_err(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (err_b) begin at = cyc; break; end
        end
    endtask

    initial begin
        rst_cnt = 1'b0;
        #2 rst_cnt = 1'b1;
        #1 chk_rst_a("reset");
        chk("reset_err_b", err_b, 0);
        @(negedge clk); rst_cnt = 1'b0;

        // Single requester, 40-cycle transaction
        req_cmd = {16'h2222, 16'hA55A, 16'h1111};
        rd_a = 16'h1234; len_a = 40;
        @(negedge clk); req = 3'b010; t0 = cyc;
        wait_wrt(0, 20, w);
        chk("t1_wrt_lat", w - t0, 1);
        chk("t1_cmd", cmd_a, 16'hA55A);
        chk("t1_gnt", gnt_a, 3'b010);
        chk("t1_busy", busy_a, 1);
        @(negedge clk);
        chk("t1_wrt_pulse", wrt_a, 0);
        wait_ack(0, 100, a, nw);
        chk("t1_ack_lat", a - w, 42);
        chk("t1_ack", ack_a, 3'b010);
        chk("t1_rsp", rsp_a, 16'h1234);
        chk("t1_extra_wrt", nw, 0);
        chk("t1_cmd_hold", cmd_a, 16'hA55A);
        @(negedge clk); req = 3'b000;
        chk("t1_ack_1cyc", ack_a, 0);
        chk("t1_rsp_hold", rsp_a, 16'h1234);

        // Round-robin with all three requesters cycling
        do_reset();
        len_a = 5; rd_a = 16'h0B0B; req = 3'b111;
        ngr = 0; last_ack = -100; rr = '{0, 0, 0};
        for (int c = 0; c < 600 && ngr < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rr[i] > 0) begin
                    rr[i]--;
                    if (rr[i] == 0) req[i] = 1'b1;
                end
            end
            if (wrt_a) begin
                exp_g = 3'b001 << (ngr % 3);
                chk("rr_gnt", gnt_a, exp_g);
                if (ngr > 0) chk("rr_spacing", (cyc - last_ack + 1) >= (GAP + 3), 1);
                ngr++;
            end
            if (ack_a != 3'b000) begin
                last_ack = cyc;
                for (int i = 0; i < 3; i++) if (ack_a[i]) begin req[i] = 1'b0; rr[i] = 2; end
            end
        end
        chk("rr_count", ngr, 6);

        // Fairness: req[0] held, req[2] raised once
        do_reset();
        len_a = 5; rd_a = 16'h0C0C;
        @(negedge clk); req = 3'b001;
        wait_wrt(0, 20, w);
        chk("fair_first_gnt", gnt_a, 3'b001);
        req[2] = 1'b1; k = 0; found = 0;
        for (int c = 0; c < 300 && found == 0 && k < 3; c++) begin
            @(negedge clk);
            if (wrt_a) begin
                k++;
                if (gnt_a == 3'b100) found = k;
            end
        end
        chk("fair_req2_by_2nd", (found >= 1 && found <= 2), 1);
        req = 3'b000;

        // Reset abandons a transaction mid-XFER and restores the round-robin pointer
        do_reset();
        len_a = 5; rd_a = 16'h5A5A;
        @(negedge clk); req = 3'b100;
        wait_wrt(0, 20, w);
        wait_ack(0, 40, a, nw);
        chk("rst_pre_rsp", rsp_a, 16'h5A5A);
        @(negedge clk); req = 3'b001; len_a = 40;
        wait_wrt(0, 20, w2);
        chk("rst_pre_gnt", gnt_a, 3'b001);
        repeat (20) @(negedge clk);
        chk("rst_pre_busy", busy_a, 1);
        rst_cnt = 1'b1;
        #1 chk_rst_a("rst_mid");
        @(negedge clk); rst_cnt = 1'b0; req = 3'b101;
        n_ack = 0; w = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack_a != 3'b000) n_ack++;
            if (wrt_a) begin w = cyc; break; end
        end
        chk("rst_no_ack", n_ack, 0);
        chk("rst_regrant_seen", w > 0, 1);
        chk("rst_regrant_gnt", gnt_a, 3'b001);
        req = 3'b000;

        // Instance b: done arrives exactly at the timeout threshold
        do_reset();
        rd_b = 16'hBEEF; len_b = 14; hang_b = 1'b0;
        @(negedge clk); req = 3'b001;
        wait_wrt(1, 20, w);
        wait_ack(1, 40, a, nw);
        chk("sim_ack_lat", a - w, 16);
        chk("sim_ack", ack_b, 3'b001);
        chk("sim_rsp", rsp_b, 16'hBEEF);
        chk("sim_err", err_b, 0);

        // Instance b: hung master
        @(negedge clk); req = 3'b010; hang_b = 1'b1; rd_b = 16'hDEAD;
        wait_wrt(1, 20, w2);
        chk("tmo_gnt", gnt_b, 3'b010);
        chk("tmo_spacing", (w2 > 0) && ((w2 - a + 1) >= (GAP + 3)), 1);
        wait_err(40, e);
        chk("tmo_err_lat", e - w2, 16);
        chk("tmo_ack", ack_b, 3'b010);
        chk("tmo_rsp_kept", rsp_b, 16'hBEEF);
        @(negedge clk); req = 3'b001; hang_b = 1'b0;
        chk("tmo_ack_1cyc", ack_b, 0);
        wait_wrt(1, 30, w);
        chk("tmo_next_gnt", gnt_b, 3'b001);
        chk("tmo_err_sticky1", err_b, 1);
        wait_ack(1, 40, a, nw);
        chk("tmo_next_ack", ack_b, 3'b001);
        chk("tmo_next_rsp", rsp_b, 16'hDEAD);
        chk("tmo_err_sticky2", err_b, 1);
        req = 3'b000;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
